// File: rtl/glyph_plotter_pkg.sv
// rtl/glyph_plotter_pkg.sv - shared glyph geometry, screen defaults and CHAR_BITES width
`ifndef CHAR_BITES
`define CHAR_BITES 7
`endif

package glyph_plotter_pkg;

  localparam int GLYPH_W      = 8;
  localparam int GLYPH_H      = 16;
  localparam int GLYPH_BITS   = GLYPH_W * GLYPH_H;
  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;

  localparam int COL_W = $clog2(GLYPH_W);
  localparam int ROW_W = $clog2(GLYPH_H);
  localparam int IDX_W = $clog2(GLYPH_BITS);

  // Row-major bitmap index with row 0 / col 0 at the MSB:
  // GLYPH_BITS-1 - (row*GLYPH_W + col), which for a power-of-two glyph is ~{row, col}.
  function automatic logic [IDX_W-1:0] bit_index(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return ~{row, col};
  endfunction

endpackage

// File: rtl/glyph_cursor.sv
// rtl/glyph_cursor.sv - glyph row/col walker giving the next pixel to present and a last-pixel flag
module glyph_cursor
  import glyph_plotter_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             advance,
  output logic [ROW_W-1:0] nxt_row,
  output logic [COL_W-1:0] nxt_col,
  output logic [IDX_W-1:0] nxt_idx,
  output logic             last
);

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             end_of_row;

  assign end_of_row = (col == COL_W'(GLYPH_W - 1));
  assign last       = end_of_row && (row == ROW_W'(GLYPH_H - 1));

  // During start the next pixel is the origin; otherwise it is the successor
  // of the current one (the last pixel wraps back to the origin).
  assign nxt_col = start ? '0 : col + 1'b1;
  assign nxt_row = start ? '0 : (end_of_row ? row + 1'b1 : row);
  assign nxt_idx = bit_index(nxt_row, nxt_col);

  // Current pixel position: set to the origin on start, stepped on each retire.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row <= '0;
      col <= '0;
    end else if (start || advance) begin
      row <= nxt_row;
      col <= nxt_col;
    end
  end

endmodule

// File: rtl/glyph_plotter.sv
// rtl/glyph_plotter.sv - text-layer glyph drawing engine; optional TRANSPARENT_BG_EN skips 0 bits
module glyph_plotter
  import glyph_plotter_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int COLOR_W  = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [`CHAR_BITES-1:0] req_char,
  input  logic [X_W-1:0]         req_x,
  input  logic [Y_W-1:0]         req_y,
  input  logic [COLOR_W-1:0]     req_fg,
  input  logic [COLOR_W-1:0]     req_bg,
  output logic [`CHAR_BITES-1:0] dec_char,
  input  logic [GLYPH_BITS-1:0]  dec_pixels,
  output logic                   plot,
  input  logic                   plot_ready,
  output logic [X_W-1:0]         plot_x,
  output logic [Y_W-1:0]         plot_y,
  output logic [COLOR_W-1:0]     plot_colour,
  output logic                   busy,
  output logic                   done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DRAW = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [`CHAR_BITES-1:0] SPACE_CHAR = {{(`CHAR_BITES-6){1'b0}}, 6'h20};
  localparam logic [X_W:0]           X_LIM      = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]           Y_LIM      = (Y_W+1)'(SCREEN_H);

  logic [1:0]            state;
  logic [X_W-1:0]        x0;
  logic [Y_W-1:0]        y0;
  logic [COLOR_W-1:0]    fg;
  logic [COLOR_W-1:0]    bg;
  logic [GLYPH_BITS-1:0] bitmap;

  logic                  load;
  logic                  retire;
  logic                  last;
  logic [ROW_W-1:0]      nxt_row;
  logic [COL_W-1:0]      nxt_col;
  logic [IDX_W-1:0]      nxt_idx;
  logic [GLYPH_BITS-1:0] src;
  logic                  pix_bit;
  logic [X_W:0]          sum_x;
  logic [Y_W:0]          sum_y;
  logic                  on_screen;
  logic                  draw_px;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign load      = (state == S_LOAD);
  // A pixel retires once accepted, or immediately when it is not being plotted.
  assign retire    = (state == S_DRAW) && (!plot || plot_ready);

  glyph_cursor u_cursor (
    .clk     (clk),
    .resetn  (resetn),
    .start   (load),
    .advance (retire),
    .nxt_row (nxt_row),
    .nxt_col (nxt_col),
    .nxt_idx (nxt_idx),
    .last    (last)
  );

  // The first pixel is prepared in LOAD, before the bitmap register has been
  // written, so it is taken straight from the decoder.
  assign src     = load ? dec_pixels : bitmap;
  assign pix_bit = src[nxt_idx];

  // Extra MSB keeps right/bottom overflow from wrapping back onto the screen.
  assign sum_x     = {1'b0, x0} + {{(X_W+1-COL_W){1'b0}}, nxt_col};
  assign sum_y     = {1'b0, y0} + {{(Y_W+1-ROW_W){1'b0}}, nxt_row};
  assign on_screen = (sum_x < X_LIM) && (sum_y < Y_LIM);

`ifdef TRANSPARENT_BG_EN
  assign draw_px = on_screen && pix_bit;
`else
  assign draw_px = on_screen;
`endif

  // Control FSM plus request latch and bitmap capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      dec_char <= SPACE_CHAR;
      x0       <= '0;
      y0       <= '0;
      fg       <= '0;
      bg       <= '0;
      bitmap   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            state    <= S_LOAD;
            dec_char <= req_char;
            x0       <= req_x;
            y0       <= req_y;
            fg       <= req_fg;
            bg       <= req_bg;
          end
        end
        S_LOAD: begin
          bitmap <= dec_pixels;
          state  <= S_DRAW;
        end
        S_DRAW: begin
          if (retire && last) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered write port: loaded for the next pixel whenever the current one
  // retires, held untouched while a write is stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      plot        <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      done        <= 1'b0;
    end else begin
      done <= retire && last;
      if (load || (retire && !last)) begin
        plot        <= draw_px;
        plot_x      <= sum_x[X_W-1:0];
        plot_y      <= sum_y[Y_W-1:0];
        plot_colour <= pix_bit ? fg : bg;
      end else if (retire) begin
        plot <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_glyph_plotter.sv
// tb/tb_glyph_plotter.sv - scoreboard bench for glyph_plotter with a small font model
`ifndef CHAR_BITES
`define CHAR_BITES 7
`endif

module tb_glyph_plotter;

`ifdef TRANSPARENT_BG_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  localparam int CNT_A = TRANSP ? 39 : 128;
  localparam int CNT_S = TRANSP ? 0 : 128;
  localparam int CNT_H = TRANSP ? 4 : 16;
  localparam int CNT_I = TRANSP ? 24 : 128;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b0;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [`CHAR_BITES-1:0] req_char = '0;
  logic [8:0]             req_x = '0;
  logic [7:0]             req_y = '0;
  logic [2:0]             req_fg = '0;
  logic [2:0]             req_bg = '0;
  logic [`CHAR_BITES-1:0] dec_char;
  logic [127:0]           dec_pixels;
  logic                   plot;
  logic                   plot_ready = 1'b1;
  logic [8:0]             plot_x;
  logic [7:0]             plot_y;
  logic [2:0]             plot_colour;
  logic                   busy;
  logic                   done;

  glyph_plotter dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_char    (req_char),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_fg      (req_fg),
    .req_bg      (req_bg),
    .dec_char    (dec_char),
    .dec_pixels  (dec_pixels),
    .plot        (plot),
    .plot_ready  (plot_ready),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_colour (plot_colour),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] font(input logic [`CHAR_BITES-1:0] c);
    case (c)
      7'h41:   return 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
      7'h48:   return 128'h0000_C6C6_C6C6_FEC6_C6C6_C6C6_0000_0000;
      7'h49:   return 128'h0000_3C18_1818_1818_1818_183C_0000_0000;
      default: return 128'h0;
    endcase
  endfunction

  assign dec_pixels = font(dec_char);

  int  checks = 0;
  int  failures = 0;
  int  n_writes = 0;
  int  n_dones = 0;
  int  last_done_cyc = 0;
  int  acc_ref = 0;
  bit  toggle = 1'b0;
  logic [19:0] exp_q[$];
  int          done_q[$];
  logic [2:0]  seen[int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int key(input int x, input int y);
    return x * 256 + y;
  endfunction

  function automatic bit visible(input logic [127:0] bmp, input int r, input int c,
                                 input int x, input int y);
    bit pix;
    pix = bmp[127 - (r * 8 + c)];
    return (x + c < 320) && (y + r < 240) && (TRANSP ? pix : 1'b1);
  endfunction

  // Expected write list for one glyph, in row-major order.
  task automatic push_model(input logic [6:0] ch, input int x, input int y,
                            input logic [2:0] fg, input logic [2:0] bg);
    logic [127:0] bmp;
    bmp = font(ch);
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (visible(bmp, r, c, x, y))
          exp_q.push_back({9'(x + c), 8'(y + r), bmp[127 - (r * 8 + c)] ? fg : bg});
      end
    end
  endtask

  // Cycles from accept to done when plot_ready is high on odd offsets (tog) or always.
  function automatic int lat_model(input logic [6:0] ch, input int x, input int y, input bit tog);
    logic [127:0] bmp;
    int t;
    bmp = font(ch);
    t = 2;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (visible(bmp, r, c, x, y) && tog && (t % 2 == 0)) t++;
        t++;
      end
    end
    return t;
  endfunction

  // Monitor: scoreboard pop on each accepted write, hold check on stalls, done timing.
  logic [19:0] held_w;
  bit          held = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      held = 1'b0;
    end else begin
      if (held) chk("stall_hold", 32'({plot, plot_x, plot_y, plot_colour}), 32'({1'b1, held_w}));
      held   = plot && !plot_ready;
      held_w = {plot_x, plot_y, plot_colour};
      if (plot && plot_ready) begin
        n_writes++;
        seen[key(int'(plot_x), int'(plot_y))] = plot_colour;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_write: got x=%0d y=%0d colour=%0d expected none",
                   plot_x, plot_y, plot_colour);
        end else begin
          chk("write", 32'({plot_x, plot_y, plot_colour}), 32'(exp_q.pop_front()));
        end
      end
      if (done) begin
        n_dones++;
        last_done_cyc = cyc;
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_done: got done at cycle %0d expected none", cyc);
        end else begin
          chk("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        end
      end
    end
  end

  // plot_ready driver: always high, or low on even offsets from the accept cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      plot_ready = toggle ? ((cyc - acc_ref) % 2 == 1) : 1'b1;
    end
  end

  // Present a request (caller is 1 time unit after a rising edge) and wait for accept.
  task automatic issue(input logic [6:0] ch, input int x, input int y,
                       input logic [2:0] fg, input logic [2:0] bg, input bit tog,
                       output int acc);
    push_model(ch, x, y, fg, bg);
    req_char  = ch;
    req_x     = 9'(x);
    req_y     = 8'(y);
    req_fg    = fg;
    req_bg    = bg;
    req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 400; k++) begin
      if (req_ready) begin
        acc     = cyc;
        acc_ref = cyc;
        toggle  = tog;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no accept expected accept within 400 cycles");
    end else begin
      done_q.push_back(acc + lat_model(ch, x, y, tog));
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_dones(input int target, input string name);
    for (int k = 0; k < 700 && n_dones < target; k++) begin
      @(posedge clk);
      #1;
    end
    chk(name, 32'(n_dones), 32'(target));
  endtask

  int base;
  int d0;
  int acc1;
  int acc2;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_plot_xyc", 32'({plot_x, plot_y, plot_colour}), 32'd0);
    chk("rst_dec_char", 32'(dec_char), 32'h20);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // 'A' at origin, fg 7 bg 0
    seen.delete();
    base = n_writes;
    d0 = n_dones;
    issue(7'h41, 0, 0, 3'd7, 3'd0, 1'b0, acc1);
    chk("A_dec_char", 32'(dec_char), 32'h41);
    chk("A_busy", 32'(busy), 32'd1);
    wait_dones(d0 + 1, "A_done");
    chk("A_writes", 32'(n_writes - base), 32'(CNT_A));
    chk("A_latency", 32'(last_done_cyc - acc1), 32'd130);
    chk("A_pix_3_2", 32'(seen[key(3, 2)]), 32'd7);
    chk("A_pix_2_3", 32'(seen[key(2, 3)]), 32'd7);
`ifndef TRANSPARENT_BG_EN
    chk("A_pix_2_2", 32'(seen[key(2, 2)]), 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("A_ready_again", 32'(req_ready), 32'd1);

    // ' ' at (10,20), fg 7 bg 1
    seen.delete();
    base = n_writes;
    d0 = n_dones;
    issue(7'h20, 10, 20, 3'd7, 3'd1, 1'b0, acc1);
    wait_dones(d0 + 1, "space_done");
    chk("space_writes", 32'(n_writes - base), 32'(CNT_S));
    chk("space_latency", 32'(last_done_cyc - acc1), 32'd130);
`ifndef TRANSPARENT_BG_EN
    chk("space_pix_10_20", 32'(seen[key(10, 20)]), 32'd1);
    chk("space_pix_17_35", 32'(seen[key(17, 35)]), 32'd1);
`endif
    @(posedge clk);
    #1;

    // 'H' at (316,236): clipped on right and bottom
    base = n_writes;
    d0 = n_dones;
    issue(7'h48, 316, 236, 3'd5, 3'd2, 1'b0, acc1);
    wait_dones(d0 + 1, "H_done");
    chk("H_writes", 32'(n_writes - base), 32'(CNT_H));
    chk("H_latency", 32'(last_done_cyc - acc1), 32'd130);
    @(posedge clk);
    #1;

    // 'I' with plot_ready toggling
    base = n_writes;
    d0 = n_dones;
    issue(7'h49, 40, 40, 3'd6, 3'd3, 1'b1, acc1);
    wait_dones(d0 + 1, "I_done");
    toggle = 1'b0;
    chk("I_writes", 32'(n_writes - base), 32'(CNT_I));
`ifndef TRANSPARENT_BG_EN
    chk("I_latency", 32'(last_done_cyc - acc1), 32'd258);
`endif
    @(posedge clk);
    #1;

    // Second request held during a draw
    base = n_writes;
    d0 = n_dones;
    issue(7'h49, 50, 60, 3'd4, 3'd2, 1'b0, acc1);
    issue(7'h41, 100, 100, 3'd3, 3'd6, 1'b0, acc2);
    chk("second_accept", 32'(acc2 - acc1), 32'd131);
    wait_dones(d0 + 2, "overlap_done");
    chk("overlap_writes", 32'(n_writes - base), 32'(CNT_I + CNT_A));
    chk("overlap_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-draw after 40 writes (default build: all pixels plotted)
    base = n_writes;
    issue(7'h41, 0, 0, 3'd7, 3'd0, 1'b0, acc1);
    for (int k = 0; k < 300 && (n_writes - base) < 40; k++) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_writes", 32'(n_writes - base), 32'(TRANSP ? 39 : 40));
    resetn = 1'b0;
    #1;
    chk("rst_mid_plot", 32'(plot), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    base = n_writes;
    d0 = n_dones;
    repeat (200) @(posedge clk);
    #1;
    chk("rst_mid_no_writes", 32'(n_writes - base), 32'd0);
    chk("rst_mid_no_done", 32'(n_dones - d0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
